// File: rtl/harvard_program_loader_pkg.sv
// Shared definitions for the Harvard program loader.
//   - OP_W / IMM_W : instruction field widths shared with the processor
//   - opcode_t     : processor opcode encoding (opcode field of a word)
//   - loader_state_t : loader sequencing states
//   - bytes_per_word : number of stream bytes needed to carry one word
package harvard_program_loader_pkg;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned IMM_W = 32;

    typedef enum logic [OP_W-1:0] {
        OPC_NOP  = 5'd0,
        OPC_LDI  = 5'd1,
        OPC_ADD  = 5'd2,
        OPC_SUB  = 5'd3,
        OPC_AND  = 5'd4,
        OPC_OR   = 5'd5,
        OPC_XOR  = 5'd6,
        OPC_LD   = 5'd7,
        OPC_ST   = 5'd8,
        OPC_JMP  = 5'd9,
        OPC_JZ   = 5'd10,
        OPC_HALT = 5'd31
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HDR,
        COLLECT,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    // ceil(w / 8)
    function automatic int unsigned bytes_per_word(input int unsigned w);
        return (w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/harvard_program_loader_if.sv
// Loader bus bundle: the inbound byte stream (in_data/in_valid/in_ready)
// and the outbound program-memory write port (wr/address/data_in).
//   master : loader side  (consumes the stream, drives the write port)
//   slave  : environment side (produces the stream, receives the writes)
interface harvard_program_loader_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = harvard_program_loader_pkg::OP_W
                                  + harvard_program_loader_pkg::IMM_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr,
        output address,
        output data_in
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr,
        input  address,
        input  data_in
    );
endinterface

// File: rtl/harvard_program_loader_word_assembler.sv
// Little-endian byte-to-word assembler.
//   clk, reset  : clock, synchronous active-high reset
//   flush       : drop any partially assembled word (byte index back to 0)
//   shift_en    : a stream byte is accepted this cycle
//   byte_in     : the accepted byte
//   word_next   : word formed by the bytes held so far plus byte_in;
//                 meaningful in the cycle word_valid is high
//   word_valid  : pulse, byte_in is the last byte of the current word
module loader_word_assembler
#(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         shift_en,
    input  logic [7:0]   byte_in,
    output logic [W-1:0] word_next,
    output logic         word_valid
);
    import harvard_program_loader_pkg::*;

    localparam int unsigned B     = bytes_per_word(W);
    localparam int unsigned SR_W  = 8 * B;
    localparam int unsigned CNT_W = (B > 1) ? $clog2(B) : 1;

    // Only the first B-1 bytes need storage; the final byte is combined
    // directly so the word is available in the cycle of its handshake.
    logic [SR_W-9:0]  hold_q;
    logic [SR_W-1:0]  full;
    logic [CNT_W-1:0] cnt_q;

    assign full       = {byte_in, hold_q};
    assign word_next  = full[W-1:0];
    assign word_valid = shift_en && (cnt_q == CNT_W'(B - 1));

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= word_valid ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (shift_en) begin
            hold_q <= full[SR_W-1:8];
        end
    end

endmodule

// File: rtl/harvard_program_loader.sv
// Harvard program loader: holds the processor in reset, optionally zeroes
// the whole program memory, then takes a header byte N followed by N
// little-endian {opcode, immediate} words from a byte stream and writes
// them to program memory starting at address 0, then releases the processor.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin a session (honoured in IDLE, DONE, ERROR)
//   bus         : stream in (in_data/in_valid/in_ready) and
//                 program-memory write port (wr/address/data_in)
//   proc_reset  : processor reset, high except after a successful load
//   busy        : session in progress
//   done        : load finished successfully (level)
//   err         : header word count out of range (level)
module harvard_program_loader
#(
    parameter int unsigned OP_W     = harvard_program_loader_pkg::OP_W,
    parameter int unsigned IMM_W    = harvard_program_loader_pkg::IMM_W,
    parameter int unsigned ADDR_W   = 7,
    parameter bit          CLEAR_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    harvard_program_loader_if.master bus,
    output logic                     proc_reset,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    import harvard_program_loader_pkg::*;

    localparam int unsigned W     = OP_W + IMM_W;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    loader_state_t     state_q, state_n;
    logic [ADDR_W-1:0] addr_q,  addr_n;
    logic [W-1:0]      data_q,  data_n;
    logic [7:0]        n_q,     n_n;
    logic              wr_q,    wr_n;
    logic              rdy_q,   rdy_n;
    logic              prst_q,  prst_n;
    logic              busy_q,  busy_n;
    logic              done_q,  done_n;
    logic              err_q,   err_n;

    logic              hs;
    logic              last_word;
    logic              word_valid;
    logic [W-1:0]      word_next;

    // Handshake is qualified by the registered ready, so in_valid never
    // reaches in_ready combinationally.
    assign hs        = rdy_q && bus.in_valid;
    assign last_word = (32'(addr_q) + 32'd1) == 32'(n_q);

    loader_word_assembler #(
        .W (W)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .flush      (state_q != COLLECT),
        .shift_en   (hs && (state_q == COLLECT)),
        .byte_in    (bus.in_data),
        .word_next  (word_next),
        .word_valid (word_valid)
    );

    // All outputs are computed as next-state values and registered, so
    // every transition below also sets the output levels of the state it
    // enters.
    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        data_n  = data_q;
        n_n     = n_q;
        wr_n    = 1'b0;
        rdy_n   = 1'b0;
        prst_n  = prst_q;
        busy_n  = busy_q;
        done_n  = done_q;
        err_n   = err_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    busy_n = 1'b1;
                    done_n = 1'b0;
                    err_n  = 1'b0;
                    addr_n = '0;
                    prst_n = 1'b1;
                    if (CLEAR_EN) begin
                        state_n = CLEAR;
                        wr_n    = 1'b1;
                        data_n  = '0;
                    end else begin
                        state_n = HDR;
                        rdy_n   = 1'b1;
                    end
                end
            end

            CLEAR: begin
                if (addr_q == '1) begin
                    addr_n  = '0;
                    state_n = HDR;
                    rdy_n   = 1'b1;
                end else begin
                    addr_n = addr_q + 1'b1;
                    wr_n   = 1'b1;
                end
            end

            HDR: begin
                rdy_n = 1'b1;
                if (hs) begin
                    if (bus.in_data == 8'd0) begin
                        state_n = DONE;
                        rdy_n   = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        prst_n  = 1'b0;
                    end else if (32'(bus.in_data) > DEPTH) begin
                        state_n = ERROR;
                        rdy_n   = 1'b0;
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                    end else begin
                        n_n     = bus.in_data;
                        state_n = COLLECT;
                    end
                end
            end

            COLLECT: begin
                rdy_n = 1'b1;
                if (word_valid) begin
                    state_n = WRITE;
                    rdy_n   = 1'b0;
                    wr_n    = 1'b1;
                    data_n  = word_next;
                end
            end

            WRITE: begin
                if (last_word) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    prst_n  = 1'b0;
                end else begin
                    addr_n  = addr_q + 1'b1;
                    state_n = COLLECT;
                    rdy_n   = 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            n_q     <= '0;
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            prst_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            n_q     <= n_n;
            wr_q    <= wr_n;
            rdy_q   <= rdy_n;
            prst_q  <= prst_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign bus.in_ready = rdy_q;
    assign bus.wr       = wr_q;
    assign bus.address  = addr_q;
    assign bus.data_in  = data_q;
    assign proc_reset   = prst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_harvard_program_loader.sv
// Testbench for harvard_program_loader.
//   dut_n : CLEAR_EN=0, checked every cycle against a transaction-level model
//   dut_c : CLEAR_EN=1, checked for the full-memory zeroing pass
module tb_harvard_program_loader;

    localparam int unsigned AW    = 7;
    localparam int unsigned W     = 37;
    localparam int unsigned B     = 5;
    localparam int unsigned DEPTH = 128;

    typedef logic [7:0] bq_t [$];

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, start0, proc_reset0, busy0, done0, err0;
    logic rst1, start1, proc_reset1, busy1, done1, err1;

    harvard_program_loader_if #(.ADDR_W(AW), .DATA_W(W)) ifn ();
    harvard_program_loader_if #(.ADDR_W(AW), .DATA_W(W)) ifc ();

    harvard_program_loader #(
        .OP_W(5), .IMM_W(32), .ADDR_W(AW), .CLEAR_EN(1'b0)
    ) dut_n (
        .clk(clk), .reset(rst0), .start(start0), .bus(ifn),
        .proc_reset(proc_reset0), .busy(busy0), .done(done0), .err(err0)
    );

    harvard_program_loader #(
        .OP_W(5), .IMM_W(32), .ADDR_W(AW), .CLEAR_EN(1'b1)
    ) dut_c (
        .clk(clk), .reset(rst1), .start(start1), .bus(ifc),
        .proc_reset(proc_reset1), .busy(busy1), .done(done1), .err(err1)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model for dut_n ----------------
    // Phases: 0 = not loading, 1 = expecting header, 2 = expecting word bytes
    int unsigned  m_phase = 0, m_k = 0, m_widx = 0, m_n = 0;
    logic [63:0]  m_acc = '0;
    logic         m_wr = 1'b0, m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_pend = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_data = '0;

    int unsigned  wr_cnt = 0;
    logic [AW-1:0] last_addr = '0;
    logic [W-1:0]  first_data = '0, last_data = '0;
    time          last_wr_t = 0, done_t = 0;
    logic         done_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            // compare current outputs against expectations
            check("wr", ifn.wr, m_wr);
            if (m_wr) begin
                check("address", ifn.address, m_addr);
                check("data_in", ifn.data_in, m_data);
            end
            check("done", done0, m_done);
            check("err", err0, m_err);
            check("busy", busy0, m_busy);
            check("proc_reset", proc_reset0, !m_done);
            check("in_ready", ifn.in_ready, (m_phase != 0) && !m_wr);

            if (ifn.wr === 1'b1) begin
                if (wr_cnt == 0) first_data = ifn.data_in;
                wr_cnt++;
                last_addr = ifn.address;
                last_data = ifn.data_in;
                last_wr_t = $time;
            end
            if (done0 === 1'b1 && !done_prev) done_t = $time;
            done_prev = done0;

            // advance expectations using the inputs seen this cycle
            if (rst0) begin
                m_phase = 0; m_k = 0; m_widx = 0; m_acc = '0;
                m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
            end else begin
                m_wr = 1'b0;
                if (start0 && !m_busy) begin
                    m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_phase = 1;
                end
                if (m_pend) begin
                    m_busy = 1'b0; m_done = 1'b1; m_pend = 1'b0;
                end
                if (ifn.in_ready && ifn.in_valid) begin
                    if (m_phase == 1) begin
                        m_n = int'(ifn.in_data);
                        if (m_n == 0) begin
                            m_busy = 1'b0; m_done = 1'b1; m_phase = 0;
                        end else if (m_n > DEPTH) begin
                            m_busy = 1'b0; m_err = 1'b1; m_phase = 0;
                        end else begin
                            m_phase = 2; m_widx = 0; m_k = 0; m_acc = '0;
                        end
                    end else if (m_phase == 2) begin
                        m_acc = m_acc | (64'(ifn.in_data) << (8 * m_k));
                        m_k++;
                        if (m_k == B) begin
                            m_wr   = 1'b1;
                            m_addr = AW'(m_widx);
                            m_data = W'(m_acc);
                            m_widx++;
                            m_k = 0; m_acc = '0;
                            if (m_widx == m_n) begin
                                m_phase = 0; m_pend = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- dut_c clear-pass monitor ----------------
    int unsigned  clr_cnt = 0;
    logic [AW-1:0] clr_exp = '0;
    time          clr_first_t = 0, clr_last_t = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst1 && ifc.wr === 1'b1) begin
                check("clr_address", ifc.address, clr_exp);
                check("clr_data_in", ifc.data_in, 0);
                if (clr_cnt == 0) clr_first_t = $time;
                clr_last_t = $time;
                clr_cnt++;
                clr_exp = clr_exp + 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_main();
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        bit hs;
        int unsigned n;
        if (gap > 0) begin
            ifn.in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        ifn.in_data  = b;
        ifn.in_valid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = ifn.in_ready;
            @(posedge clk); #1;
            n++;
        end
        check("byte_accept_timeout", hs, 1'b1);
    endtask

    task automatic send_stream(input bq_t s, input int unsigned gap, input int pulse_at);
        for (int i = 0; i < s.size(); i++) begin
            if (i == pulse_at) begin
                ifn.in_valid = 1'b0;
                start0 = 1'b1;
                @(posedge clk); #1;
                start0 = 1'b0;
            end
            send_byte(s[i], gap);
        end
        ifn.in_valid = 1'b0;
    endtask

    task automatic wait_for(input string nm, input bit want_err);
        int unsigned n = 0;
        while (((want_err ? err0 : done0) !== 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(nm, want_err ? err0 : done0, 1'b1);
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_wr"},         ifn.wr,       0);
        check({p, "_address"},    ifn.address,  0);
        check({p, "_data_in"},    ifn.data_in,  0);
        check({p, "_proc_reset"}, proc_reset0,  1);
        check({p, "_in_ready"},   ifn.in_ready, 0);
        check({p, "_busy"},       busy0,        0);
        check({p, "_done"},       done0,        0);
        check({p, "_err"},        err0,         0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bq_t s2, s1;
        int unsigned n;
        s2 = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
        s1 = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFE};

        rst0 = 1'b1; start0 = 1'b0; ifn.in_valid = 1'b0; ifn.in_data = '0;
        rst1 = 1'b1; start1 = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check_reset_state("rst");
        check("rst_c_proc_reset", proc_reset1, 1);
        check("rst_c_busy", busy1, 0);
        check("rst_c_done", done1, 0);
        check("rst_c_wr", ifc.wr, 0);

        // CLEAR_EN=1, N=0: full zeroing pass then done
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("clr_hdr_ready", ifc.in_ready, 1);
        @(posedge clk); #1;
        ifc.in_data = 8'h00; ifc.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        n = 0;
        while (done1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("clr_done", done1, 1);
        check("clr_proc_reset", proc_reset1, 0);
        check("clr_err", err1, 0);
        check("clr_count", clr_cnt, 128);
        check("clr_contiguous", clr_last_t - clr_first_t, 127 * 10);

        // CLEAR_EN=0, two words, back-to-back bytes
        wr_cnt = 0;
        start_main();
        send_stream(s2, 0, -1);
        wait_for("t2_done", 1'b0);
        check("t2_wr_count", wr_cnt, 2);
        check("t2_first_data", first_data, 37'h03_0000_0001);
        check("t2_last_addr", last_addr, 1);
        check("t2_last_data", last_data, 37'h1F_FFFF_FFFF);
        check("t2_done_latency", done_t - last_wr_t, 10);
        check("t2_proc_reset", proc_reset0, 0);

        // same stream with 3 idle cycles before every byte
        wr_cnt = 0;
        start_main();
        send_stream(s2, 3, -1);
        wait_for("t3_done", 1'b0);
        check("t3_wr_count", wr_cnt, 2);
        check("t3_first_data", first_data, 37'h03_0000_0001);
        check("t3_last_data", last_data, 37'h1F_FFFF_FFFF);
        check("t3_done_latency", done_t - last_wr_t, 10);

        // header 200 > 128 -> error, then recovery
        wr_cnt = 0;
        start_main();
        send_stream('{8'hC8}, 0, -1);
        wait_for("t4_err", 1'b1);
        repeat (3) @(negedge clk);
        check("t4_err_held", err0, 1);
        check("t4_proc_reset", proc_reset0, 1);
        check("t4_no_write", wr_cnt, 0);
        start_main();
        send_stream(s2, 0, -1);
        wait_for("t4_recover_done", 1'b0);
        check("t4_err_cleared", err0, 0);
        check("t4_wr_count", wr_cnt, 2);

        // reset in the middle of the first word
        wr_cnt = 0;
        start_main();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        ifn.in_valid = 1'b0;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        check("midrst_no_write", wr_cnt, 0);
        start_main();
        send_stream(s1, 0, -1);
        wait_for("t5_done", 1'b0);
        check("t5_wr_count", wr_cnt, 1);
        check("t5_addr", last_addr, 0);
        check("t5_data", last_data, 37'h1E_DDCC_BBAA);

        // start pulsed while collecting is ignored
        wr_cnt = 0;
        start_main();
        send_stream(s2, 1, 3);
        wait_for("t6_done", 1'b0);
        check("t6_wr_count", wr_cnt, 2);
        check("t6_last_addr", last_addr, 1);
        check("t6_last_data", last_data, 37'h1F_FFFF_FFFF);

        repeat (4) @(negedge clk);
        check("clr_total", clr_cnt, 128);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/harvard_program_loader.md
Name: harvard_program_loader

Overview:
- Upstream stage of the Harvard processor; drives its program-memory write port (wr, address, data_in) and holds the processor in reset while loading.
- Accepts a byte stream over a valid/ready handshake, assembles {opcode, immediate} instruction words and writes them to consecutive addresses from 0.
- Optionally clears program memory first, then releases the processor to run.

Parameters:
- OP_W, 5, opcode field width (matches the shared opcode enum)
- IMM_W, 32, immediate field width
- ADDR_W, 7, program-memory address width
- CLEAR_EN, 1, when 1, write all-zero words to every address before loading

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load session; sampled only in IDLE, DONE or ERROR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- wr  out  1  program-memory write strobe to the processor
- address  out  ADDR_W  write address
- data_in  out  OP_W+IMM_W  instruction word, {opcode, immediate}
- proc_reset  out  1  processor reset; high while loading
- busy  out  1  session in progress
- done  out  1  load completed successfully; level output
- err  out  1  bad header; level output

Behaviour:
- Reset values: wr=0, address=0, data_in=0, proc_reset=1, in_ready=0, busy=0, done=0, err=0. State=IDLE.
- Word width W=OP_W+IMM_W. Bytes per word B=ceil(W/8); B=5 at defaults.
- Bytes arrive little-endian. Bits of the last byte above W are discarded.
- IDLE:
  - in_ready=0.
  - On start: busy=1, done=0, err=0, address=0, proc_reset=1.
  - Go to CLEAR if CLEAR_EN=1, else go to HDR.
- CLEAR:
  - wr=1 and data_in=0 every cycle; address increments each cycle.
  - After writing address 2^ADDR_W-1: address=0, go to HDR.
  - Takes 2^ADDR_W cycles.
- HDR:
  - in_ready=1; one handshake accepts count N.
  - N=0: go to DONE.
  - N>2^ADDR_W: go to ERROR.
  - Otherwise latch N and the byte index to 0, then go to COLLECT.
- COLLECT:
  - in_ready=1; each handshake shifts the byte into an assembly register.
  - On the B-th byte go to WRITE; in_ready drops in the next cycle.
  - Gaps in in_valid stall with no timeout.
- WRITE:
  - Exactly one cycle: wr=1, data_in=assembled word, address=current index.
  - Next cycle: wr=0. If words written == N, go to DONE. Otherwise address+1 and go to COLLECT.
  - Latency from the final byte handshake to wr is 1 cycle.
- DONE:
  - busy=0, done=1, proc_reset=0 (processor runs), in_ready=0.
  - address and data_in hold their last values.
  - start begins a new session, which reasserts proc_reset the same cycle that busy rises.
- ERROR:
  - busy=0, err=1, proc_reset stays 1, in_ready=0.
  - Only start or reset leaves this state.
- wr is 0 in every state except CLEAR and WRITE.
- start while busy is ignored.
- A write to address 2^ADDR_W-1 never wraps, because N is bounded by the header check.
- reset at any cycle, including mid-word or mid-CLEAR, returns everything to reset values. The partial word is discarded and no write is issued in that cycle.
- Registered outputs only; no combinational path from in_valid to in_ready.

Decomposition:
- Shared package holds:
  - the opcode enum and OP_W/IMM_W constants
  - the loader state enum: IDLE, CLEAR, HDR, COLLECT, WRITE, DONE, ERROR
  - a function computing B from W
- One natural sub-module: loader_word_assembler, the byte shift register plus byte counter with a word_valid pulse.
- The FSM and address counter live in the top module.

Test Plan:
- CLEAR_EN=1, start, N=0 -> 128 consecutive wr cycles with data_in=0 at addresses 0..127; then done=1, proc_reset=0, err=0.
- CLEAR_EN=0, stream 02, 01 00 00 00 03, FF FF FF FF 1F -> wr at addr 0 with 37'h03_0000_0001, then at addr 1 with 37'h1F_FFFF_FFFF; done=1 one cycle after the second write.
- Same stream with in_valid low for 3 cycles between every byte -> identical writes and addresses; wr never asserted during gaps.
- Header 0xC8 (200) -> err=1, proc_reset=1, wr never asserted; a subsequent start with a valid stream clears err and loads normally.
- reset asserted after the 3rd byte of word 1 (N=2) -> all outputs at reset values next cycle; a fresh start with N=1 writes address 0 only.
- start pulsed during COLLECT -> no effect; session completes with the original N.
